// File: rtl/evm_pkg.sv
// Shared definitions for the ballot-unit and result display stages:
// state encoding, {s1,s2} mode codes, candidate count and default saturation.
package evm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        BEEP,
        LOCK
    } state_t;

    localparam logic [1:0] MODE_VOTE   = 2'b10;
    localparam logic [1:0] MODE_RESULT = 2'b01;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    localparam int unsigned NUM_CAND          = 4;
    localparam int unsigned COUNT_W           = 4;
    localparam int unsigned MAX_COUNT_DEFAULT = 9;

    function automatic logic is_one_hot(input logic [NUM_CAND-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-level filter: the output follows
// the synchronized input only after it has differed for DEB_CYCLES cycles.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any cycle where the levels agree restarts the stability window.
            if (sync2 != level) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/vote_recorder.sv
// Ballot unit: conditions the candidate buttons and ballot release, runs the
// one-vote-per-release FSM and keeps four saturating per-candidate counts.
module vote_recorder #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned BEEP_CYCLES = 8,
    parameter int unsigned MAX_COUNT   = evm_pkg::MAX_COUNT_DEFAULT
) (
    input  logic       c0,
    input  logic       rst,
    input  logic       s1,
    input  logic       s2,
    input  logic       ballot,
    input  logic [3:0] btn,
    output logic [3:0] res1,
    output logic [3:0] res2,
    output logic [3:0] res3,
    output logic [3:0] res4,
    output logic       ready,
    output logic       beep,
    output logic       sat
);

    import evm_pkg::*;

    localparam int unsigned BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    logic [NUM_CAND-1:0] btn_db;
    logic                bal_s1;
    logic                bal_s2;
    logic                bal_prev;
    logic                bal_rise;
    logic [1:0]          mode;
    state_t              state;
    state_t              state_nx;
    logic [BW-1:0]       beep_cnt;
    logic                cast;
    logic                clear;
    logic [COUNT_W-1:0]  count [NUM_CAND];

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (c0),
            .rst   (rst),
            .raw   (btn[i]),
            .level (btn_db[i])
        );
    end

    always_ff @(posedge c0) begin
        if (rst) begin
            bal_s1   <= 1'b0;
            bal_s2   <= 1'b0;
            bal_prev <= 1'b0;
        end else begin
            bal_s1   <= ballot;
            bal_s2   <= bal_s1;
            bal_prev <= bal_s2;
        end
    end

    assign bal_rise = bal_s2 & ~bal_prev;
    assign mode     = {s1, s2};

    always_comb begin
        state_nx = state;
        cast     = 1'b0;
        clear    = 1'b0;
        case (state)
            IDLE: begin
                if (mode == MODE_CLEAR) begin
                    clear = 1'b1;
                end else if (mode == MODE_VOTE && bal_rise && btn_db == '0) begin
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (mode != MODE_VOTE) begin
                    state_nx = IDLE;
                end else if (is_one_hot(btn_db)) begin
                    cast     = 1'b1;
                    state_nx = BEEP;
                end
            end
            BEEP: begin
                if (beep_cnt == BW'(BEEP_CYCLES - 1)) state_nx = LOCK;
            end
            LOCK: begin
                if (btn_db == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ready/beep are decoded from the next state so they register alongside it.
    always_ff @(posedge c0) begin
        if (rst) begin
            state    <= IDLE;
            beep_cnt <= '0;
            ready    <= 1'b0;
            beep     <= 1'b0;
        end else begin
            state    <= state_nx;
            beep_cnt <= (state == BEEP && state_nx == BEEP) ? beep_cnt + 1'b1 : '0;
            ready    <= (state_nx == ARMED);
            beep     <= (state_nx == BEEP);
        end
    end

    always_ff @(posedge c0) begin
        if (rst || clear) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) count[i] <= '0;
            sat <= 1'b0;
        end else if (cast) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                if (btn_db[i]) begin
                    if (count[i] >= COUNT_W'(MAX_COUNT)) sat <= 1'b1;
                    else count[i] <= count[i] + 1'b1;
                end
            end
        end
    end

    assign res1 = count[0];
    assign res2 = count[1];
    assign res3 = count[2];
    assign res4 = count[3];

endmodule

// File: doc/vote_recorder.md
Name: vote_recorder

Overview:
- Ballot-unit stage that sits directly upstream of the result display stage.
- Accepts candidate button presses and maintains four per-candidate vote counts.
- Drives the counts on res1..res4, which the display stage consumes.
- One vote is accepted per presiding-officer ballot release; each accepted vote is acknowledged with a beep pulse.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles required before a synchronized button level is accepted.
- BEEP_CYCLES, 8: length of the beep pulse after an accepted vote.
- MAX_COUNT, 9: saturation value for each count, matching the display's 0-9 decode.

Ports:
- c0  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s1  in  1  mode switch; voting mode is s1=1, s2=0.
- s2  in  1  mode switch; clear mode is s1=1, s2=1.
- ballot  in  1  presiding-officer release; the rising edge arms one vote.
- btn  in  4  candidate buttons, btn[0]=candidate 1 .. btn[3]=candidate 4, active-high, asynchronous.
- res1  out  4  vote count, candidate 1.
- res2  out  4  vote count, candidate 2.
- res3  out  4  vote count, candidate 3.
- res4  out  4  vote count, candidate 4.
- ready  out  1  high while ARMED (voter may press a button).
- beep  out  1  vote-accepted acknowledge pulse.
- sat  out  1  sticky flag, set when a vote hits a count already at MAX_COUNT.

Behaviour:
- Reset: rst=1 at an edge forces the following.
  - res1..res4=0, sat=0, ready=0, beep=0, state=IDLE.
  - Synchronizers, debouncers and the ballot edge register are cleared.
  - Reset overrides everything, including a vote in progress: the vote is lost and counts are zeroed.
- Input conditioning:
  - Each btn bit passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level btn_db[i] changes only after the synchronized level differs from btn_db[i] for DEB_CYCLES consecutive cycles.
  - ballot passes through a 2-flop synchronizer. Rising edge = synchronized 1 and previous 0.
- States and transitions:
  - IDLE: ready=0. Go to ARMED on a ballot rising edge while in voting mode and btn_db==0. A ballot edge with any button held is ignored.
  - ARMED: ready=1. If btn_db is exactly one-hot at edge N, the selected count increments at edge N (visible from cycle N+1) and state goes to BEEP. Zero buttons, or two or more simultaneous buttons, keep the state in ARMED with no count change.
  - BEEP: beep=1 for exactly BEEP_CYCLES cycles, then go to LOCK.
  - LOCK: wait until btn_db==0, then go to IDLE. A held button can therefore never cast a second vote.
  - Further ballot edges in ARMED, BEEP or LOCK are ignored; they do not queue.
- Leaving voting mode: if s1/s2 leave voting mode while in ARMED, the next edge returns to IDLE and no vote is cast. BEEP and LOCK complete normally.
- Clear mode (s1=1, s2=1) while in IDLE: at the next edge res1..res4 and sat go to 0. Clear mode has no effect in other states.
- Count arithmetic:
  - Counts are unsigned 4-bit and saturate at MAX_COUNT.
  - A vote for a count already at MAX_COUNT leaves it unchanged, sets sat=1, and still runs BEEP/LOCK.
  - Counts never exceed 9 and never wrap.
- Result mode (s1=0, s2=1) and all other modes: counts hold and the block stays in, or returns to, IDLE.
- Outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package evm_pkg holds:
  - State encoding (IDLE, ARMED, BEEP, LOCK).
  - Mode constants MODE_VOTE=2'b10, MODE_RESULT=2'b01, MODE_CLEAR=2'b11, as {s1,s2}.
  - Candidate count NUM_CAND=4.
  - Default MAX_COUNT=9, shared with the display stage.
- Sub-module btn_debounce: 2-flop synchronizer plus stable counter, parameterized by DEB_CYCLES. Instantiated four times.

Test Plan:
- Reset, then ballot edge in voting mode, then btn[1] held 10 cycles.
  - Required: ready=1 after the ballot edge.
  - Required: res2=1 exactly 2+DEB_CYCLES+1 cycles after the press.
  - Required: beep high for exactly 8 cycles.
  - Required: IDLE only after release, with res1=res3=res4=0.
- In ARMED, press btn[0] and btn[2] together, release them, then press btn[3] alone.
  - Required: no count change during the double press.
  - Required: res4=1 after the single press; ready stays 1 until that vote.
- Hold btn[0] across two ballot edges, the second arriving during LOCK.
  - Required: res1 increments once only.
  - Required: the second ballot is ignored and ready stays 0.
- Cast 10 votes for candidate 3.
  - Required: res3 reaches 9 and stays 9.
  - Required: sat=1 after the 10th vote, and beep still pulses 8 cycles.
- Leave voting mode while ARMED, then set clear mode in IDLE with res1=3.
  - Required: the next edge returns to IDLE with no vote.
  - Required: after the clear, res1..res4=0 and sat=0.
- Assert rst during BEEP with res2=5.
  - Required: next cycle res2=0, beep=0, ready=0, state IDLE.
